// File: rtl/exec_alu_mc.sv
// ============================================================================
//  Module      : exec_alu_mc
//  Description : Registered execute-stage ALU with four-way operand
//                forwarding, single-cycle ops, an iterative shift-add
//                unsigned multiplier (start/busy/valid) and a {C,N,Z}
//                flag register with hold-carry and restore-from-stack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_alu_mc #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [1:0]       alu_src1_select,
    input  logic [1:0]       alu_src2_select,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] write_back_data,
    input  logic [WIDTH-1:0] reg_data1_from_mem,
    input  logic [WIDTH-1:0] reg_data2_from_mem,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       carry_sel,
    input  logic             flagreg_enable,
    input  logic             flag_regsel,
    input  logic [2:0]       conditions_from_memory_pop,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic [2:0]       flag_register
);

    localparam logic [3:0] c_OP_NOT = 4'b0000;
    localparam logic [3:0] c_OP_INC = 4'b0001;
    localparam logic [3:0] c_OP_DEC = 4'b0010;
    localparam logic [3:0] c_OP_ADD = 4'b0011;
    localparam logic [3:0] c_OP_SUB = 4'b0100;
    localparam logic [3:0] c_OP_AND = 4'b0101;
    localparam logic [3:0] c_OP_OR  = 4'b0110;
    localparam logic [3:0] c_OP_SHL = 4'b0111;
    localparam logic [3:0] c_OP_SHR = 4'b1000;
    localparam logic [3:0] c_OP_MUL = 4'b1001;
    localparam logic [3:0] c_OP_SAR = 4'b1010;

    // Iteration counter runs 0..WIDTH-1; the last value is the final step.
    localparam logic [SHW-2:0] c_CNT_LAST = (SHW-1)'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   w_op1;
    logic [WIDTH-1:0]   w_op2;
    logic               w_issue;
    logic               w_is_mul;

    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c;
    logic               w_shift_big;
    logic               w_shift_zero;
    logic [SHW-2:0]     w_shamt_lo;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH:0]     w_sar;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHW-2:0]     r_cnt;
    logic               r_mul_fen;
    logic [1:0]         r_mul_csel;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_mul_last;

    logic [WIDTH-1:0]   r_result;
    logic               r_valid;
    logic [2:0]         r_flags;
    logic [2:0]         w_issue_flags;
    logic [2:0]         w_mul_flags;

    // Carry source selection shared by single-cycle and multiply flag writes.
    function automatic logic f_pick_c(input logic [1:0] sel, input logic alu_c,
                                      input logic cur_c);
        case (sel)
            2'b00:   f_pick_c = alu_c;
            2'b01:   f_pick_c = 1'b1;
            2'b10:   f_pick_c = 1'b0;
            default: f_pick_c = cur_c;
        endcase
    endfunction

    // Operand forwarding muxes.
    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        case (alu_src1_select)
            2'b00:   w_op1 = write_back_data;
            2'b01:   w_op1 = reg_data1_from_mem;
            2'b10:   w_op1 = read_data1;
            default: w_op1 = '0;
        endcase
        case (alu_src2_select)
            2'b00:   w_op2 = read_data2;
            2'b01:   w_op2 = write_back_data;
            2'b10:   w_op2 = reg_data2_from_mem;
            default: w_op2 = {{(WIDTH-SHW){1'b0}}, shamt};
        endcase
    end

    assign w_issue  = start && (r_state == S_IDLE);
    assign w_is_mul = (alu_op == c_OP_MUL);

    // Shifts use one extra bit so the last bit shifted out lands in a known
    // position; amounts of WIDTH or more are handled as a separate case.
    assign w_shift_big  = |w_op2[WIDTH-1:SHW-1];
    assign w_shift_zero = (w_op2 == '0);
    assign w_shamt_lo   = w_op2[SHW-2:0];
    assign w_shl        = {1'b0, w_op1} << w_shamt_lo;
    assign w_shr        = {w_op1, 1'b0} >> w_shamt_lo;
    assign w_sar        = $signed({w_op1, 1'b0}) >>> w_shamt_lo;

    // Single-cycle ALU result and carry.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (alu_op)
            c_OP_NOT: w_alu_res = ~w_op1;
            c_OP_INC: {w_alu_c, w_alu_res} = {1'b0, w_op1} + (WIDTH+1)'(1);
            c_OP_DEC: {w_alu_c, w_alu_res} = {1'b0, w_op1} - (WIDTH+1)'(1);
            c_OP_ADD: {w_alu_c, w_alu_res} = {1'b0, w_op1} + {1'b0, w_op2};
            c_OP_SUB: {w_alu_c, w_alu_res} = {1'b0, w_op1} - {1'b0, w_op2};
            c_OP_AND: w_alu_res = w_op1 & w_op2;
            c_OP_OR:  w_alu_res = w_op1 | w_op2;
            c_OP_SHL: begin
                if (w_shift_zero) begin
                    w_alu_res = w_op1;
                end else if (!w_shift_big) begin
                    w_alu_res = w_shl[WIDTH-1:0];
                    w_alu_c   = w_shl[WIDTH];
                end
            end
            c_OP_SHR: begin
                if (w_shift_zero) begin
                    w_alu_res = w_op1;
                end else if (!w_shift_big) begin
                    w_alu_res = w_shr[WIDTH:1];
                    w_alu_c   = w_shr[0];
                end
            end
            c_OP_SAR: begin
                if (w_shift_zero) begin
                    w_alu_res = w_op1;
                end else if (w_shift_big) begin
                    w_alu_res = {WIDTH{w_op1[WIDTH-1]}};
                    w_alu_c   = w_op1[WIDTH-1];
                end else begin
                    w_alu_res = w_sar[WIDTH:1];
                    w_alu_c   = w_sar[0];
                end
            end
            default: begin
                w_alu_res = '0;
                w_alu_c   = 1'b0;
            end
        endcase
    end

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == c_CNT_LAST);

    assign w_issue_flags = {f_pick_c(carry_sel, w_alu_c, r_flags[2]),
                            w_alu_res[WIDTH-1], ~|w_alu_res};
    assign w_mul_flags   = {f_pick_c(r_mul_csel, |w_acc_next[2*WIDTH-1:WIDTH], r_flags[2]),
                            w_acc_next[WIDTH-1], ~|w_acc_next[WIDTH-1:0]};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next-state: enter MUL on a multiply issue, leave after the last step.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_issue && w_is_mul) w_state_next = S_MUL;
            S_MUL:   if (w_mul_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shift-add multiplier datapath; flag controls are captured at issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
            r_mul_fen  <= 1'b0;
            r_mul_csel <= 2'b00;
        end else if (w_issue && w_is_mul) begin
            r_acc      <= '0;
            r_mcand    <= {{WIDTH{1'b0}}, w_op1};
            r_mplier   <= w_op2;
            r_cnt      <= '0;
            r_mul_fen  <= flagreg_enable;
            r_mul_csel <= carry_sel;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Result register, valid pulse and flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_flags  <= 3'b000;
        end else begin
            r_valid <= 1'b0;
            if (w_issue && !w_is_mul) begin
                r_result <= w_alu_res;
                r_valid  <= 1'b1;
            end else if (w_mul_last) begin
                r_result <= w_acc_next[WIDTH-1:0];
                r_valid  <= 1'b1;
            end

            // A stack restore wins over any concurrent ALU flag write.
            if (flagreg_enable && flag_regsel) begin
                r_flags <= conditions_from_memory_pop;
            end else if (w_issue && !w_is_mul && flagreg_enable) begin
                r_flags <= w_issue_flags;
            end else if (w_mul_last && r_mul_fen) begin
                r_flags <= w_mul_flags;
            end
        end
    end

    assign result        = r_result;
    assign result_valid  = r_valid;
    assign busy          = (r_state == S_MUL);
    assign flag_register = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_exec_alu_mc.sv
// ============================================================================
//  Module      : tb_exec_alu_mc
//  Description : Self-checking bench for exec_alu_mc: directed scenarios
//                followed by randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_alu_mc;

    localparam int W  = 16;
    localparam int SW = $clog2(W) + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [3:0]    alu_op;
    logic [1:0]    alu_src1_select;
    logic [1:0]    alu_src2_select;
    logic [W-1:0]  read_data1;
    logic [W-1:0]  read_data2;
    logic [W-1:0]  write_back_data;
    logic [W-1:0]  reg_data1_from_mem;
    logic [W-1:0]  reg_data2_from_mem;
    logic [SW-1:0] shamt;
    logic [1:0]    carry_sel;
    logic          flagreg_enable;
    logic          flag_regsel;
    logic [2:0]    conditions_from_memory_pop;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          busy;
    logic [2:0]    flag_register;

    int            checks;
    int            errors;
    logic [2:0]    m_flags;
    logic [W-1:0]  m_result;

    exec_alu_mc #(.WIDTH(W)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .start                      (start),
        .alu_op                     (alu_op),
        .alu_src1_select            (alu_src1_select),
        .alu_src2_select            (alu_src2_select),
        .read_data1                 (read_data1),
        .read_data2                 (read_data2),
        .write_back_data            (write_back_data),
        .reg_data1_from_mem         (reg_data1_from_mem),
        .reg_data2_from_mem         (reg_data2_from_mem),
        .shamt                      (shamt),
        .carry_sel                  (carry_sel),
        .flagreg_enable             (flagreg_enable),
        .flag_regsel                (flag_regsel),
        .conditions_from_memory_pop (conditions_from_memory_pop),
        .result                     (result),
        .result_valid               (result_valid),
        .busy                       (busy),
        .flag_register              (flag_register)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference ALU: returns {C, result} from plain unsigned arithmetic.
    function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int              n;
        logic [W-1:0]    r;
        logic            c;
        longint unsigned full;
        n = int'(b);
        r = '0;
        c = 1'b0;
        case (op)
            4'd0: r = ~a;
            4'd1: begin full = longint'(a) + 1; r = full[W-1:0]; c = (full >= (64'd1 << W)); end
            4'd2: begin r = a - 1'b1; c = (a == '0); end
            4'd3: begin full = longint'(a) + longint'(b); r = full[W-1:0]; c = (full >= (64'd1 << W)); end
            4'd4: begin r = a - b; c = (a < b); end
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: begin
                if (n == 0) r = a;
                else if (n < W) begin r = a << n; c = a[W-n]; end
            end
            4'd8: begin
                if (n == 0) r = a;
                else if (n < W) begin r = a >> n; c = a[n-1]; end
            end
            4'd10: begin
                if (n == 0) r = a;
                else if (n >= W) begin r = {W{a[W-1]}}; c = a[W-1]; end
                else begin
                    r = a >> n;
                    if (a[W-1]) r = r | ~({W{1'b1}} >> n);
                    c = a[n-1];
                end
            end
            4'd9: begin
                full = longint'(a) * longint'(b);
                r = full[W-1:0];
                c = ((full >> W) != 0);
            end
            default: begin r = '0; c = 1'b0; end
        endcase
        return {c, r};
    endfunction

    function automatic logic pick_c(input logic [1:0] cs, input logic c, input logic cur);
        case (cs)
            2'd0:    return c;
            2'd1:    return 1'b1;
            2'd2:    return 1'b0;
            default: return cur;
        endcase
    endfunction

    function automatic logic [W-1:0] op1_of(input logic [1:0] s);
        case (s)
            2'd0:    return write_back_data;
            2'd1:    return reg_data1_from_mem;
            2'd2:    return read_data1;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] op2_of(input logic [1:0] s);
        case (s)
            2'd0:    return read_data2;
            2'd1:    return write_back_data;
            2'd2:    return reg_data2_from_mem;
            default: return {{(W-SW){1'b0}}, shamt};
        endcase
    endfunction

    task automatic rand_data();
        read_data1         = W'($urandom);
        read_data2         = W'($urandom);
        write_back_data    = W'($urandom);
        reg_data1_from_mem = W'($urandom);
        reg_data2_from_mem = W'($urandom);
        shamt              = SW'($urandom);
    endtask

    // Single-cycle issue at a negedge; checks the result one edge later.
    task automatic issue1(input string tag, input logic [3:0] op, input logic [1:0] s1,
                          input logic [1:0] s2, input logic en, input logic rsel,
                          input logic [1:0] cs, input logic [2:0] pop);
        logic [W:0] e;
        e = ref_alu(op, op1_of(s1), op2_of(s2));
        alu_op = op; alu_src1_select = s1; alu_src2_select = s2;
        flagreg_enable = en; flag_regsel = rsel; carry_sel = cs;
        conditions_from_memory_pop = pop;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; flagreg_enable = 1'b0; flag_regsel = 1'b0;
        if (en) m_flags = rsel ? pop : {pick_c(cs, e[W], m_flags[2]), e[W-1], (e[W-1:0] == '0)};
        m_result = e[W-1:0];
        chk({tag, "_res"},   32'(result),        32'(m_result));
        chk({tag, "_valid"}, 32'(result_valid),  32'(1));
        chk({tag, "_busy"},  32'(busy),          32'(0));
        chk({tag, "_flags"}, 32'(flag_register), 32'(m_flags));
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(result_valid),  32'(0));
        chk({tag, "_hold"},  32'(result),        32'(m_result));
        chk({tag, "_flags"}, 32'(flag_register), 32'(m_flags));
    endtask

    task automatic pop_only(input logic [2:0] pop);
        flagreg_enable = 1'b1; flag_regsel = 1'b1; conditions_from_memory_pop = pop;
        @(negedge clk);
        flagreg_enable = 1'b0; flag_regsel = 1'b0;
        m_flags = pop;
        chk("pop_flags", 32'(flag_register), 32'(m_flags));
        chk("pop_valid", 32'(result_valid),  32'(0));
    endtask

    // Multiply issue; optional ignored starts and a stack restore while busy.
    task automatic do_mul(input string tag, input logic [1:0] s1, input logic [1:0] s2,
                          input logic en, input logic [1:0] cs, input logic junk,
                          input logic pop_mid, input logic [2:0] pop_val);
        logic [W:0] e;
        e = ref_alu(4'd9, op1_of(s1), op2_of(s2));
        alu_op = 4'd9; alu_src1_select = s1; alu_src2_select = s2;
        flagreg_enable = en; flag_regsel = 1'b0; carry_sel = cs;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; flagreg_enable = 1'b0;
        for (int k = 1; k <= W; k++) begin
            chk({tag, "_busy"},  32'(busy),          32'(1));
            chk({tag, "_nval"},  32'(result_valid),  32'(0));
            chk({tag, "_hold"},  32'(result),        32'(m_result));
            chk({tag, "_bflg"},  32'(flag_register), 32'(m_flags));
            if (junk) begin
                rand_data();
                alu_op = 4'($urandom); alu_src1_select = 2'($urandom);
                alu_src2_select = 2'($urandom); carry_sel = 2'($urandom);
                start = 1'b1;
            end
            if (pop_mid && k == 3) begin
                flagreg_enable = 1'b1; flag_regsel = 1'b1; conditions_from_memory_pop = pop_val;
            end else begin
                flagreg_enable = 1'b0; flag_regsel = 1'b0;
            end
            @(negedge clk);
            if (pop_mid && k == 3) m_flags = pop_val;
        end
        start = 1'b0; flagreg_enable = 1'b0; flag_regsel = 1'b0;
        if (en) m_flags = {pick_c(cs, e[W], m_flags[2]), e[W-1], (e[W-1:0] == '0)};
        m_result = e[W-1:0];
        chk({tag, "_valid"}, 32'(result_valid),  32'(1));
        chk({tag, "_done"},  32'(busy),          32'(0));
        chk({tag, "_res"},   32'(result),        32'(m_result));
        chk({tag, "_flags"}, 32'(flag_register), 32'(m_flags));
    endtask

    initial begin
        logic [3:0] rop;
        checks = 0; errors = 0;
        m_flags = 3'b000; m_result = '0;
        rst = 1'b1; start = 1'b0; alu_op = 4'd0;
        alu_src1_select = 2'd0; alu_src2_select = 2'd0;
        read_data1 = '0; read_data2 = '0; write_back_data = '0;
        reg_data1_from_mem = '0; reg_data2_from_mem = '0; shamt = '0;
        carry_sel = 2'd0; flagreg_enable = 1'b0; flag_regsel = 1'b0;
        conditions_from_memory_pop = 3'b000;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_res",   32'(result),        32'(0));
        chk("rst_valid", 32'(result_valid),  32'(0));
        chk("rst_busy",  32'(busy),          32'(0));
        chk("rst_flags", 32'(flag_register), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Add with overflow.
        read_data1 = 16'hFFFF; read_data2 = 16'h0001;
        issue1("add_ovf", 4'b0011, 2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000);
        chk("add_ovf_const", 32'(flag_register), 32'(3'b101));
        idle_check("add_ovf_pulse");

        // SHL via shamt, in range and at WIDTH.
        read_data1 = 16'h8001; shamt = SW'(1);
        issue1("shl1", 4'b0111, 2'b10, 2'b11, 1'b1, 1'b0, 2'b00, 3'b000);
        chk("shl1_const", 32'(result), 32'(16'h0002));
        shamt = SW'(16);
        issue1("shl16", 4'b0111, 2'b10, 2'b11, 1'b1, 1'b0, 2'b00, 3'b000);
        chk("shl16_const", 32'(flag_register), 32'(3'b001));
        idle_check("shl_pulse");

        // Multiply with starts asserted while busy.
        read_data1 = 16'h0100; read_data2 = 16'h0100;
        do_mul("mul", 2'b10, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 3'b000);
        chk("mul_const", 32'(flag_register), 32'(3'b101));
        idle_check("mul_pulse");

        // Stack restore racing an ALU issue.
        rand_data();
        issue1("race", 4'b0011, 2'b10, 2'b00, 1'b1, 1'b1, 2'b00, 3'b101);

        // Hold-carry and disabled flag writes.
        pop_only(3'b110);
        read_data1 = 16'd5; read_data2 = 16'd5;
        issue1("sub_hold", 4'b0100, 2'b10, 2'b00, 1'b1, 1'b0, 2'b11, 3'b000);
        chk("sub_hold_const", 32'(flag_register), 32'(3'b101));
        pop_only(3'b010);
        issue1("sub_noen", 4'b0100, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000);

        // Reset three cycles into a multiply.
        rand_data();
        alu_op = 4'd9; alu_src1_select = 2'b10; alu_src2_select = 2'b00;
        flagreg_enable = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; flagreg_enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_flags = 3'b000; m_result = '0;
        chk("mrst_res",   32'(result),        32'(0));
        chk("mrst_busy",  32'(busy),          32'(0));
        chk("mrst_valid", 32'(result_valid),  32'(0));
        chk("mrst_flags", 32'(flag_register), 32'(0));
        for (int k = 0; k < W + 2; k++) begin
            idle_check("mrst_quiet");
            chk("mrst_qbusy", 32'(busy), 32'(0));
        end
        read_data1 = 16'h1234; read_data2 = 16'h0101;
        issue1("post_rst_add", 4'b0011, 2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000);

        // Randomized back-to-back traffic with interleaved multiplies.
        for (int i = 0; i < 300; i++) begin
            rand_data();
            rop = 4'($urandom);
            if (rop == 4'd9)
                do_mul("rmul", 2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
                       1'b1, 1'($urandom), 3'($urandom));
            else
                issue1("rop", rop, 2'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 3) == 0), 2'($urandom), 3'($urandom));
            if (i % 16 == 15) idle_check("ridle");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
